// File: rtl/regfile_mp.sv
// Multi-ported register file with a per-register pending scoreboard.
// After reset an internal sweep zeroes every register (INIT), then the
// file accepts traffic (RUN). Register 0 is hard-wired to zero.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
// data to matching read ports while in RUN.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 2,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*XLEN-1:0]   wr_data,
  input  logic                     alloc_en,
  input  logic [AW-1:0]            alloc_addr
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [AW-1:0]       sweep_cnt_q, sweep_cnt_d;
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [XLEN-1:0]     mem_q [NUM_REGS];
  logic                run;
  logic [NUM_WR-1:0]   wr_go;

  assign run   = (state_q == ST_RUN);
  assign ready = run;

  // Qualify write ports: RUN only, never register 0, lowest port wins a clash.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    wr_go = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      wr_go[p] = run && wr_en[p] && (wr_addr[p*AW +: AW] != '0);
      for (int q = 0; q < p; q++) begin
        if (wr_en[q] && (wr_addr[q*AW +: AW] == wr_addr[p*AW +: AW])) begin
          wr_go[p] = 1'b0;
        end
      end
    end
  end

  // Sweep counter and INIT -> RUN transition after the last register is cleared.
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    if (state_q == ST_INIT) begin
      sweep_cnt_d = sweep_cnt_q + AW'(1);
      if (sweep_cnt_q == AW'(NUM_REGS - 1)) begin
        state_d = ST_RUN;
      end
    end
  end

  // Pending bits: writes clear, alloc sets afterwards so it wins on a collision.
  always_comb begin
    pend_d = pend_q;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_go[p]) begin
        pend_d[wr_addr[p*AW +: AW]] = 1'b0;
      end
    end
    if (run && alloc_en && (alloc_addr != '0)) begin
      pend_d[alloc_addr] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // Control state with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= ST_INIT;
      sweep_cnt_q <= '0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      pend_q      <= pend_d;
    end
  end

  // Register storage: cleared by the sweep in INIT, written by qualified ports in RUN.
  always_ff @(posedge clk) begin
    // NOTE: storage deliberately has no reset so it can map onto distributed RAM; the sweep clears it.
    if (state_q == ST_INIT) begin
      mem_q[sweep_cnt_q] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_go[p]) begin
          mem_q[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
        end
      end
    end
  end

  // Combinational read ports; zero in INIT and for register 0.
  always_comb begin
    rd_data    = '0;
    rd_pending = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (run && (rd_addr[i*AW +: AW] != '0)) begin
        rd_data[i*XLEN +: XLEN] = mem_q[rd_addr[i*AW +: AW]];
        rd_pending[i]           = pend_q[rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        // Qualified ports never share an address, so at most one matches.
        for (int p = 0; p < NUM_WR; p++) begin
          if (wr_go[p] && (wr_addr[p*AW +: AW] == rd_addr[i*AW +: AW])) begin
            rd_data[i*XLEN +: XLEN] = wr_data[p*XLEN +: XLEN];
          end
        end
`else
        // Without forwarding, reads return the stored value only.
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized + directed bench for regfile_mp. A driver issues one input
// vector per cycle and pushes the predicted outputs into a queue; a monitor
// pops and compares on the falling edge.
module tb_regfile_mp;
  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int NUM_RD   = 4;
  localparam int NUM_WR   = 2;
  localparam int AW       = 5;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   ready;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_pending;
  logic [NUM_WR-1:0]      wr_en;
  logic [NUM_WR*AW-1:0]   wr_addr;
  logic [NUM_WR*XLEN-1:0] wr_data;
  logic                   alloc_en;
  logic [AW-1:0]          alloc_addr;

  regfile_mp #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected response for one cycle.
  typedef struct {
    logic [NUM_RD*XLEN-1:0] data;
    logic [NUM_RD-1:0]      pend;
    logic                   rdy;
    bit                     use_lit;
    logic [XLEN-1:0]        lit;
    bit                     pchk;
    logic                   pexp;
    int                     id;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: registers, pending flags, and cycles left before ready.
  logic [XLEN-1:0] m_mem  [NUM_REGS];
  bit              m_pend [NUM_REGS];
  int              m_init_left = 0;
  bit              m_known     = 0;

  function automatic exp_t predict();
    exp_t e;
    logic [AW-1:0] a;
    e.data = '0; e.pend = '0; e.use_lit = 0; e.lit = '0; e.pchk = 0; e.pexp = 0; e.id = 0;
    e.rdy = (m_init_left == 0);
    for (int i = 0; i < NUM_RD; i++) begin
      a = rd_addr[i*AW +: AW];
      if (e.rdy && a != 0) begin
        e.data[i*XLEN +: XLEN] = m_mem[a];
        e.pend[i] = m_pend[a];
`ifdef REGFILE_BYPASS_EN
        for (int w = NUM_WR - 1; w >= 0; w--)
          if (wr_en[w] && wr_addr[w*AW +: AW] == a) e.data[i*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
`endif
      end
    end
    return e;
  endfunction

  // Apply the inputs that were present at the clock edge just taken.
  task automatic model_step();
    logic [AW-1:0] a;
    if (rst) begin
      m_known = 1;
      m_init_left = NUM_REGS;
      for (int r = 0; r < NUM_REGS; r++) begin m_mem[r] = '0; m_pend[r] = 0; end
    end else if (!m_known) begin
      m_known = 0;
    end else if (m_init_left > 0) begin
      m_init_left--;
    end else begin
      // Highest port first so the lowest port's data is what remains.
      for (int w = NUM_WR - 1; w >= 0; w--) begin
        a = wr_addr[w*AW +: AW];
        if (wr_en[w] && a != 0) m_mem[a] = wr_data[w*XLEN +: XLEN];
      end
      for (int w = 0; w < NUM_WR; w++) begin
        a = wr_addr[w*AW +: AW];
        if (wr_en[w] && a != 0) m_pend[a] = 0;
      end
      if (alloc_en && alloc_addr != 0) m_pend[alloc_addr] = 1;
    end
  endtask

  // One cycle: predict, push, clock, update model.
  task automatic cycle(input int id = 0, input bit use_lit = 0, input logic [XLEN-1:0] lit = '0,
                       input bit pchk = 0, input logic pexp = 1'b0);
    exp_t e;
    if (m_known) begin
      e = predict();
      e.id = id; e.use_lit = use_lit; e.lit = lit; e.pchk = pchk; e.pexp = pexp;
      sb_q.push_back(e);
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Monitor: compare every presented cycle against the oldest prediction.
  exp_t me;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      me = sb_q.pop_front();
      check("ready", {127'd0, ready}, {127'd0, me.rdy});
      check("rd_data", rd_data, me.data);
      check("rd_pending", {124'd0, rd_pending}, {124'd0, me.pend});
      if (me.use_lit) check($sformatf("directed%0d_rd0_data", me.id), {96'd0, rd_data[XLEN-1:0]}, {96'd0, me.lit});
      if (me.pchk) check($sformatf("directed%0d_rd0_pending", me.id), {127'd0, rd_pending[0]}, {127'd0, me.pexp});
    end
  end

  task automatic idle();
    wr_en = '0; alloc_en = 1'b0; alloc_addr = '0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NUM_RD; i++) rd_addr[i*AW +: AW] = AW'($urandom_range(0, NUM_REGS - 1));
    for (int w = 0; w < NUM_WR; w++) begin
      wr_addr[w*AW +: AW] = AW'($urandom_range(0, NUM_REGS - 1));
      wr_data[w*XLEN +: XLEN] = $urandom();
    end
    if ($urandom_range(0, 3) == 0) wr_addr[AW +: AW] = wr_addr[0 +: AW];
    wr_en      = NUM_WR'($urandom_range(0, 3));
    alloc_en   = 1'($urandom_range(0, 1));
    alloc_addr = AW'($urandom_range(0, NUM_REGS - 1));
    if ($urandom_range(0, 3) == 0) alloc_addr = wr_addr[0 +: AW];
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en[p] = 1'b1; wr_addr[p*AW +: AW] = a; wr_data[p*XLEN +: XLEN] = d;
  endtask

  // Counts INIT cycles (ready low) until ready rises, with random traffic that must be ignored.
  task automatic measure_init(input string name);
    int  lo = 0;
    bit  done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      rand_inputs();
      if (ready === 1'b1) done = 1; else lo++;
      cycle();
    end
    check(name, lo, 32);
  endtask

  logic [XLEN-1:0] old7;

  initial begin
    rst = 1'b1; rd_addr = '0; idle();
    cycle(); cycle();
    rst = 1'b0;
    measure_init("reset_init_cycles");

    // Write conflict: port 0 must win.
    idle(); rd_addr[0 +: AW] = 5;
    set_wr(0, 5, 32'hAAAA_0000); set_wr(1, 5, 32'h5555_FFFF);
    cycle(1);
    idle();
    cycle(2, 1, 32'hAAAA_0000);

    // Register 0: write and alloc are both ineffective.
    idle(); rd_addr[0 +: AW] = 0;
    set_wr(0, 0, 32'hDEAD_BEEF); alloc_en = 1'b1; alloc_addr = 0;
    cycle(3, 1, 32'h0, 1, 1'b0);
    idle();
    cycle(4, 1, 32'h0, 1, 1'b0);

    // Forwarding behaviour on register 7.
    old7 = 32'h0BAD_F00D;
    idle(); set_wr(0, 7, old7); cycle();
    idle(); rd_addr[0 +: AW] = 7; set_wr(1, 7, 32'h1234_5678);
`ifdef REGFILE_BYPASS_EN
    cycle(5, 1, 32'h1234_5678);
`else
    cycle(5, 1, old7);
`endif
    idle();
    cycle(6, 1, 32'h1234_5678);

    // Scoreboard on register 9.
    idle(); rd_addr[0 +: AW] = 9; alloc_en = 1'b1; alloc_addr = 9;
    cycle();
    idle();
    cycle(7, 0, '0, 1, 1'b1);
    set_wr(0, 9, 32'h0000_0999); alloc_en = 1'b1; alloc_addr = 9;
    cycle(8, 0, '0, 1, 1'b1);
    idle();
    cycle(9, 0, '0, 1, 1'b1);
    set_wr(1, 9, 32'h0000_9999);
    cycle(10, 0, '0, 1, 1'b1);
    idle();
    cycle(11, 0, '0, 1, 1'b0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      rand_inputs();
      cycle();
    end

    // Mid-sweep reset with pending bits set beforehand.
    idle(); alloc_en = 1'b1; alloc_addr = 9; cycle();
    idle();
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int k = 0; k < 10; k++) begin rand_inputs(); cycle(); end
    rst = 1'b1; idle(); cycle(); rst = 1'b0;
    measure_init("midsweep_init_cycles");
    idle(); rd_addr[0 +: AW] = 9;
    cycle(12, 1, 32'h0, 1, 1'b0);
    for (int k = 0; k < 50; k++) begin rand_inputs(); cycle(); end

    idle();
    @(negedge clk); #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The module SHALL have parameters (name, default, meaning):
- XLEN, 32, register width in bits
- NUM_REGS, 32, register count; power of two, >= 2
- NUM_RD, 4, read port count
- NUM_WR, 2, write port count
- AW = $clog2(NUM_REGS), derived address width
REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock
- rst, in, 1, reset: synchronous, active-high
- ready, out, 1, initialisation sweep complete
- rd_addr, in, NUM_RD*AW, read addresses; port i at [i*AW +: AW]
- rd_data, out, NUM_RD*XLEN, read data; port i at [i*XLEN +: XLEN]
- rd_pending, out, NUM_RD, scoreboard pending bit of each read address
- wr_en, in, NUM_WR, per-port write enable
- wr_addr, in, NUM_WR*AW, write addresses
- wr_data, in, NUM_WR*XLEN, write data
- alloc_en, in, 1, mark one destination register pending
- alloc_addr, in, AW, register to mark

Function
REQ-003 Register 0 SHALL read as zero, SHALL never be written, and SHALL never be pending.
REQ-004 Reads SHALL be combinational with zero latency.
REQ-005 Each enabled write SHALL update its register at the rising clk edge.
REQ-006 When several enabled write ports target the same register, the lowest-indexed port SHALL win; the other ports' data for that register SHALL be dropped.
REQ-007 The FSM SHALL have two states, INIT and RUN.
- INIT writes zero to register sweep_cnt each cycle and increments sweep_cnt (AW bits).
- INIT moves to RUN on the cycle after sweep_cnt == NUM_REGS-1.
- RUN is held until rst.
REQ-008 ready SHALL be 1 only in RUN.
REQ-009 In INIT:
- rd_data SHALL be all zeros.
- rd_pending SHALL be all zeros.
- wr_en and alloc_en SHALL be ignored.
REQ-010 Each register SHALL have a pending bit.
- alloc_en sets the bit of alloc_addr at the next edge.
- Any enabled write to a register clears its bit at the next edge.
REQ-011 When alloc and a write target the same register in the same cycle, the write SHALL update the data and the alloc SHALL win: the pending bit ends at 1.
REQ-012 rd_pending[i] SHALL show the current registered pending bit of rd_addr port i, with no bypass.
REQ-013 alloc_addr == 0 SHALL have no effect.

Reset
REQ-014 While rst is sampled high at an edge, the block SHALL load state = INIT, sweep_cnt = 0, ready = 0, and all pending bits = 0.
REQ-015 Register contents SHALL have no reset; they are cleared only by the INIT sweep, so the storage maps to distributed RAM.
REQ-016 rst asserted mid-sweep or during RUN SHALL restart the sweep from register 0; the total INIT time after rst deasserts SHALL be exactly NUM_REGS cycles.

Configuration
REQ-017 The macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
- Defined: in RUN, a read whose address matches an enabled same-cycle write (address != 0) SHALL return that write's data combinationally. The REQ-006 winner applies when several ports match.
- Undefined: reads return the stored value only; new data is visible from the cycle after the write.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Reset: rst high 2 cycles, then low -> ready = 0 for exactly 32 cycles, ready = 1 on cycle 33, all reads 0.
- Write conflict: in RUN, wr_en = 2'b11 with both addresses 5 and data 0xAAAA_0000 / 0x5555_FFFF -> next cycle, reading 5 returns 0xAAAA_0000.
- Register 0: write 0xDEAD_BEEF to address 0 and alloc address 0 -> rd_data = 0 and rd_pending = 0 for address 0.
- Bypass, macro defined: write 0x1234_5678 to address 7 while reading 7 -> rd_data = 0x1234_5678 in the same cycle.
- Bypass, macro undefined: same stimulus -> rd_data = the old value that cycle, 0x1234_5678 the next cycle.
- Scoreboard: alloc 9; next cycle read 9 -> rd_pending = 1. Write 9 together with alloc 9 -> still 1. Write 9 alone -> 0 the following cycle.
- Reset mid-sweep: assert rst at sweep cycle 10 for 1 cycle -> ready rises exactly 32 cycles after rst deasserts, and all pending bits are 0.
